// File: rtl/rsp_framer_pkg.sv
// Shared constants, FSM state type and VLQ helpers for the host-bound response framer.
package rsp_framer_pkg;

    localparam logic [7:0] SYNC_BYTE      = 8'h7E;
    localparam logic [7:0] SEQ_BASE       = 8'h10;
    localparam int         FRAME_OVERHEAD = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENC,
        ST_HDR,
        ST_CODE,
        ST_PAY,
        ST_CRC,
        ST_SYNC
    } state_t;

    // Thresholds are nested, so the byte count is one plus the number of conditions met.
    function automatic logic [2:0] vlq_len(input logic signed [31:0] v);
        logic [2:0] n;
        n = 3'd1;
        if (v >= 32'sh0000_0060 || v < -32'sh0000_0020) n = 3'd2;
        if (v >= 32'sh0000_3000 || v < -32'sh0000_1000) n = 3'd3;
        if (v >= 32'sh0018_0000 || v < -32'sh0008_0000) n = 3'd4;
        if (v >= 32'sh0C00_0000 || v < -32'sh0400_0000) n = 3'd5;
        return n;
    endfunction

    // Group k is bits [7k+6:7k] of the sign-extended value; every byte but the last has bit7 set.
    function automatic logic [7:0] vlq_byte(input logic [31:0] v, input logic [2:0] k,
                                            input logic last);
        logic [6:0] g;
        case (k)
            3'd0:    g = v[6:0];
            3'd1:    g = v[13:7];
            3'd2:    g = v[20:14];
            3'd3:    g = v[27:21];
            default: g = {{3{v[31]}}, v[31:28]};
        endcase
        return {~last, g};
    endfunction

endpackage

// File: rtl/crc16_mcrf4xx.sv
// Byte-serial CRC-16/MCRF4XX: reflected polynomial 0x1021 (0x8408), init 0xFFFF, no final xor.
module crc16_mcrf4xx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_reg;
    logic [15:0] crc_next;

    always_comb begin
        crc_next = crc_reg ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ 16'h8408) : (crc_next >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg <= 16'hFFFF;
        end else if (clr) begin
            crc_reg <= 16'hFFFF;
        end else if (en) begin
            crc_reg <= crc_next;
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/rsp_framer.sv
// Response framer: param FIFO -> VLQ payload buffer -> LEN/SEQ/code/payload/CRC/0x7E byte stream.
// Define RSP_FRAMER_CRC_EN to build the CRC engine; otherwise the CRC positions carry 0x00 0x00.
module rsp_framer
    import rsp_framer_pkg::*;
#(
    parameter int MSG_MAX    = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [32:0] param_data,
    input  logic        param_write,
    input  logic        cmd_done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        err_ovf
);

    localparam int               FIFO_AW   = $clog2(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam int               PAY_MAX   = MSG_MAX - 10;
    localparam int               PAY_AW    = $clog2(PAY_MAX);
    localparam logic [7:0]       PAY_LIMIT = 8'(PAY_MAX);

    // ---------------- input FIFO: entries are {done, raw, data[31:0]} ----------------
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg, wr_ptr1;
    logic [FIFO_AW:0]   fifo_cnt_reg;
    logic               push0, push1, pop, fifo_drop;
    logic [33:0]        fifo_mem [FIFO_DEPTH];
    logic [33:0]        head;

    // Payload word takes the first free slot; a same-cycle done marker goes right behind it.
    assign push0     = param_write && (fifo_cnt_reg != FIFO_FULL);
    assign push1     = cmd_done && ((fifo_cnt_reg + (FIFO_AW + 1)'(push0)) != FIFO_FULL);
    assign fifo_drop = (param_write && !push0) || (cmd_done && !push1);
    assign wr_ptr1   = wr_ptr_reg + FIFO_AW'(push0);

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
        logic [33:0] entry_reg;
        always_ff @(posedge clk) begin
            if (push0 && wr_ptr_reg == FIFO_AW'(gi)) begin
                entry_reg <= {1'b0, param_data};
            end else if (push1 && wr_ptr1 == FIFO_AW'(gi)) begin
                entry_reg <= {2'b10, param_data[31:0]};
            end
        end
        assign fifo_mem[gi] = entry_reg;
    end

    assign head = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_reg + FIFO_AW'(push0) + FIFO_AW'(push1);
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
            end
            fifo_cnt_reg <= fifo_cnt_reg + (FIFO_AW + 1)'(push0) + (FIFO_AW + 1)'(push1)
                          - (FIFO_AW + 1)'(pop);
        end
    end

    // ---------------- encoder / emitter FSM ----------------
    state_t      state_reg, state_next;
    logic [7:0]  idx_reg, idx_next;
    logic [7:0]  pay_cnt_reg, pay_cnt_next;
    logic [3:0]  seq_reg, seq_next;
    logic [31:0] code_reg, code_next;
    logic        ovf_reg, ovf_clr, ovf_buf_set;
    logic        buf_we;
    logic [7:0]  buf_wdata, rd_data_reg;
    logic [7:0]  pay_buf [PAY_MAX];
    logic [15:0] crc_val;
    logic        xfer;

    logic        head_done, head_raw;
    logic [31:0] head_data;
    logic [2:0]  enc_len, enc_k, code_len, code_k;
    logic        enc_last;
    logic [7:0]  len_byte;

    assign head_done = head[33];
    assign head_raw  = head[32];
    assign head_data = head[31:0];
    assign enc_len   = vlq_len(head_data);
    assign enc_k     = enc_len - 3'd1 - idx_reg[2:0];
    assign enc_last  = head_raw || (enc_k == 3'd0);
    assign code_len  = vlq_len(code_reg);
    assign code_k    = code_len - 3'd1 - idx_reg[2:0];
    assign len_byte  = 8'(FRAME_OVERHEAD) + {5'd0, code_len} + pay_cnt_reg;

    assign out_valid = state_reg inside {ST_HDR, ST_CODE, ST_PAY, ST_CRC, ST_SYNC};
    assign busy      = out_valid;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        pay_cnt_next = pay_cnt_reg;
        seq_next     = seq_reg;
        code_next    = code_reg;
        pop          = 1'b0;
        buf_we       = 1'b0;
        buf_wdata    = head_raw ? head_data[7:0] : vlq_byte(head_data, enc_k, enc_k == 3'd0);
        ovf_clr      = 1'b0;
        ovf_buf_set  = 1'b0;
        err_ovf      = 1'b0;
        out_data     = 8'h00;
        unique case (state_reg)
            ST_IDLE: begin
                if (fifo_cnt_reg != '0) begin
                    state_next = ST_ENC;
                    idx_next   = '0;
                end
            end
            ST_ENC: begin
                if (head_done) begin
                    pop      = 1'b1;
                    idx_next = '0;
                    if (ovf_reg) begin
                        err_ovf      = 1'b1;
                        ovf_clr      = 1'b1;
                        pay_cnt_next = '0;
                        state_next   = ST_IDLE;
                    end else if (pay_cnt_reg == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        code_next  = head_data;
                        state_next = ST_HDR;
                    end
                end else begin
                    if (pay_cnt_reg < PAY_LIMIT) begin
                        buf_we       = 1'b1;
                        pay_cnt_next = pay_cnt_reg + 8'd1;
                    end else begin
                        ovf_buf_set = 1'b1;
                    end
                    if (enc_last) begin
                        pop        = 1'b1;
                        idx_next   = '0;
                        state_next = ST_IDLE;
                    end else begin
                        idx_next = idx_reg + 8'd1;
                    end
                end
            end
            ST_HDR: begin
                out_data = (idx_reg == 8'd0) ? len_byte : (SEQ_BASE | {4'h0, seq_reg});
                if (xfer) begin
                    if (idx_reg == 8'd1) begin
                        state_next = ST_CODE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 8'd1;
                    end
                end
            end
            ST_CODE: begin
                out_data = vlq_byte(code_reg, code_k, code_k == 3'd0);
                if (xfer) begin
                    if (code_k == 3'd0) begin
                        state_next = (pay_cnt_reg != '0) ? ST_PAY : ST_CRC;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 8'd1;
                    end
                end
            end
            ST_PAY: begin
                out_data = rd_data_reg;
                if (xfer) begin
                    if (idx_reg == pay_cnt_reg - 8'd1) begin
                        state_next = ST_CRC;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 8'd1;
                    end
                end
            end
            ST_CRC: begin
                out_data = (idx_reg == 8'd0) ? crc_val[15:8] : crc_val[7:0];
                if (xfer) begin
                    if (idx_reg == 8'd1) begin
                        state_next = ST_SYNC;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 8'd1;
                    end
                end
            end
            ST_SYNC: begin
                out_data = SYNC_BYTE;
                if (xfer) begin
                    seq_next     = seq_reg + 4'd1;
                    pay_cnt_next = '0;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            pay_cnt_reg <= '0;
            seq_reg     <= '0;
            code_reg    <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            pay_cnt_reg <= pay_cnt_next;
            seq_reg     <= seq_next;
            code_reg    <= code_next;
            // A drop in the same cycle as the clearing marker belongs to the next response.
            ovf_reg     <= (ovf_reg && !ovf_clr) || ovf_buf_set || fifo_drop;
        end
    end

    // Read address tracks idx_next so rd_data_reg already holds the byte PAY presents.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            pay_buf[pay_cnt_reg[PAY_AW-1:0]] <= buf_wdata;
        end
        rd_data_reg <= pay_buf[idx_next[PAY_AW-1:0]];
    end

`ifdef RSP_FRAMER_CRC_EN
    logic crc_clr, crc_en;
    assign crc_clr = (state_reg == ST_ENC) && (state_next == ST_HDR);
    assign crc_en  = xfer && (state_reg inside {ST_HDR, ST_CODE, ST_PAY});

    crc16_mcrf4xx u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .data  (out_data),
        .crc   (crc_val)
    );
`else
    assign crc_val = 16'h0000;
`endif

endmodule

// File: tb/tb_rsp_framer.sv
// Directed self-checking bench for rsp_framer plus a standalone check of crc16_mcrf4xx.
module tb_rsp_framer;
    import rsp_framer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [32:0] param_data;
    logic        param_write, cmd_done;
    logic [7:0]  out_data;
    logic        out_valid, out_ready, busy, err_ovf;

    logic        crc_clr, crc_en;
    logic [7:0]  crc_data;
    logic [15:0] crc_out;

    always #5 clk = ~clk;

    rsp_framer #(.MSG_MAX(128), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .param_data  (param_data),
        .param_write (param_write),
        .cmd_done    (cmd_done),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .err_ovf     (err_ovf)
    );

    crc16_mcrf4xx u_crc_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .data  (crc_data),
        .crc   (crc_out)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ovf_pulses = 0;
    int         rx_base  = 0;
    logic [7:0] rx_q [$];

    always @(negedge clk) begin
        if (out_valid && out_ready) rx_q.push_back(out_data);
        if (err_ovf) ovf_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [7:0] b [$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[i]) begin
            c = c ^ {8'h00, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    // All drive tasks start and end one time unit after a rising edge.
    task automatic put_word(input logic [32:0] w);
        param_data  = w;
        param_write = 1'b1;
        @(posedge clk); #1;
        param_write = 1'b0;
        param_data  = '0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic put_done(input logic [31:0] code);
        param_data = {1'b0, code};
        cmd_done   = 1'b1;
        @(posedge clk); #1;
        cmd_done   = 1'b0;
        param_data = '0;
    endtask

    task automatic expect_frame(input string tag, input logic [3:0] seq, input logic [7:0] body [$]);
        logic [7:0]  f [$];
        logic [15:0] c;
        int          waited;
        f.push_back(8'(body.size() + FRAME_OVERHEAD));
        f.push_back(SEQ_BASE | {4'h0, seq});
        foreach (body[i]) f.push_back(body[i]);
`ifdef RSP_FRAMER_CRC_EN
        c = crc_model(f);
`else
        c = 16'h0000;
`endif
        f.push_back(c[15:8]);
        f.push_back(c[7:0]);
        f.push_back(SYNC_BYTE);
        waited = 0;
        while ((rx_q.size() - rx_base) < f.size() && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, ".count"}, 32'(rx_q.size() - rx_base), 32'(f.size()));
        for (int i = 0; i < f.size(); i++) begin
            check_eq($sformatf("%s.byte%0d", tag, i),
                     (rx_base + i < rx_q.size()) ? 32'(rx_q[rx_base + i]) : 32'hDEAD,
                     32'(f[i]));
        end
        check_eq({tag, ".busy_low"}, 32'(busy), 32'd0);
        rx_base = rx_q.size();
    endtask

    task automatic wait_rx(input int n);
        int waited = 0;
        while ((rx_q.size() - rx_base) < n && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check_eq("wait_rx.bytes", 32'((rx_q.size() - rx_base) >= n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b [$];
        rst_n = 1'b0; param_data = '0; param_write = 1'b0; cmd_done = 1'b0; out_ready = 1'b1;
        crc_clr = 1'b0; crc_en = 1'b0; crc_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst.out_data", 32'(out_data), 32'h00);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.err_ovf", 32'(err_ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // CRC engine check value over ASCII "123456789"
        crc_clr = 1'b1;
        @(posedge clk); #1;
        crc_clr = 1'b0;
        check_eq("crc.init", 32'(crc_out), 32'hFFFF);
        for (int i = 0; i < 9; i++) begin
            crc_data = 8'(8'h31 + i);
            crc_en   = 1'b1;
            @(posedge clk); #1;
        end
        crc_en = 1'b0;
        check_eq("crc.check", 32'(crc_out), 32'h6F91);

        // int 100, code 5
        put_word({1'b0, 32'd100});
        put_done(32'd5);
        b = '{8'h05, 8'h80, 8'h64};
        expect_frame("f_int100", 4'h0, b);

        // -1, 0x0C000000, 0 with code 1: LEN 0x0D, SEQ 0x11
        put_word({1'b0, 32'hFFFF_FFFF});
        put_word({1'b0, 32'h0C00_0000});
        put_word({1'b0, 32'h0000_0000});
        put_done(32'd1);
        b = '{8'h01, 8'h7F, 8'h80, 8'hE0, 8'h80, 8'h80, 8'h00, 8'h00};
        expect_frame("f_multi", 4'h1, b);

        // empty response: no frame
        put_done(32'd9);
        repeat (20) @(posedge clk);
        #1;
        check_eq("empty.no_frame", 32'(rx_q.size() - rx_base), 32'd0);
        check_eq("empty.no_err", 32'(ovf_pulses), 32'd0);

        // 119 raw bytes overflow the 118-byte buffer
        for (int i = 0; i < 119; i++) put_word({1'b1, 24'h0, 8'(i)});
        put_done(32'd3);
        repeat (20) @(posedge clk);
        #1;
        check_eq("ovf.no_frame", 32'(rx_q.size() - rx_base), 32'd0);
        check_eq("ovf.pulses", 32'(ovf_pulses), 32'd1);

        // next good frame keeps seq 2; negative code -100 -> FF 1C
        put_word({1'b1, 32'h0000_00AA});
        put_done(32'hFFFF_FF9C);
        b = '{8'hFF, 8'h1C, 8'hAA};
        expect_frame("f_after_ovf", 4'h2, b);

        // backpressure for 10 cycles while 0x33 is presented in the payload
        put_word({1'b1, 32'h11});
        put_word({1'b1, 32'h22});
        put_word({1'b1, 32'h33});
        put_word({1'b1, 32'h44});
        put_word({1'b1, 32'h55});
        put_done(32'd300);
        wait_rx(6);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("stall.valid", 32'(out_valid), 32'd1);
            check_eq("stall.data", 32'(out_data), 32'h33);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        b = '{8'h82, 8'h2C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        expect_frame("f_stall", 4'h3, b);

        // 17 frames: SEQ walks through 0x1F and wraps to 0x10
        for (int k = 0; k < 17; k++) begin
            put_word({1'b1, 24'h0, 8'(k)});
            put_done(32'd0);
            b = '{8'h00, 8'(k)};
            expect_frame($sformatf("f_seq%0d", k), 4'(4 + k), b);
        end

        // reset asserted while the payload is being emitted
        put_word({1'b1, 32'hA1});
        put_word({1'b1, 32'hA2});
        put_word({1'b1, 32'hA3});
        put_word({1'b1, 32'hA4});
        put_done(32'd0);
        wait_rx(4);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst.out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst.busy", 32'(busy), 32'd0);
        check_eq("midrst.out_data", 32'(out_data), 32'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rx_base = rx_q.size();
        put_word({1'b1, 32'h5A});
        put_done(32'd7);
        b = '{8'h07, 8'h5A};
        expect_frame("f_after_rst", 4'h0, b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
